// File: rtl/vga_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : vga_ball_engine
//  Purpose  : VGA timing generator with N_BALLS bouncing coloured discs.
//             Pixel logic runs at half the system clock through an internal
//             enable. The pixel path is two ticks deep and sync/blank are
//             delayed to stay aligned with it.
//  Ports    : clk         - system clock (only clock)
//             rst         - asynchronous reset, active low
//             pause       - high freezes ball positions at frame boundaries
//             VGA_HS/VS   - active-low syncs
//             VGA_R/G/B   - 8-bit colour, zero outside the active region
//             VGA_BLANK_N - high in the active region
//             VGA_CLOCK   - DAC pixel clock (inverted enable phase)
//             frame_start - one-clk pulse when both counters wrap to 0
//  Revision : 1.0 - initial release
// ============================================================================
module vga_ball_engine #(
    parameter int H_ACT   = 640,
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int V_ACT   = 480,
    parameter int V_FRONT = 11,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 32,
    parameter int N_BALLS = 4,
    parameter int RADIUS  = 30,
    parameter int SPEED   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_BLANK_N,
    output logic       VGA_CLOCK,
    output logic       frame_start
);

    localparam int c_H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int c_V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int c_H_TOTAL = c_H_BLANK + H_ACT;
    localparam int c_V_TOTAL = c_V_BLANK + V_ACT;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_X_MAX   = H_ACT - 1 - RADIUS;
    localparam int c_Y_MAX   = V_ACT - 1 - RADIUS;

    localparam logic [23:0]        c_R2    = 24'(RADIUS * RADIUS);
    localparam logic signed [12:0] c_RAD_S = 13'(RADIUS);
    localparam logic signed [12:0] c_XMX_S = 13'(c_X_MAX);
    localparam logic signed [12:0] c_YMX_S = 13'(c_Y_MAX);

    function automatic logic [23:0] f_colour(input int idx);
        case (idx % 4)
            0:       f_colour = 24'h0000ff;
            1:       f_colour = 24'h00ff00;
            2:       f_colour = 24'hff0000;
            default: f_colour = 24'hffffff;
        endcase
    endfunction

    logic            r_pix_en;
    logic            w_tick;
    logic [c_HW-1:0] r_hcnt;
    logic [c_VW-1:0] r_vcnt;
    logic            w_h_last;
    logic            w_v_last;
    logic            w_hs0;
    logic            w_vs0;
    logic            w_act0;
    logic [11:0]     w_x0;
    logic [11:0]     w_y0;
    logic            r_hs1;
    logic            r_vs1;
    logic            r_act1;
    logic [N_BALLS-1:0] w_hit;
    logic [23:0]     w_rgb;

    assign w_tick    = r_pix_en;
    assign VGA_CLOCK = ~r_pix_en;
    assign w_h_last  = (r_hcnt == c_HW'(c_H_TOTAL - 1));
    assign w_v_last  = (r_vcnt == c_VW'(c_V_TOTAL - 1));

    // Line/frame order is front porch, sync, back porch, then active.
    assign w_hs0  = !((r_hcnt >= c_HW'(H_FRONT)) && (r_hcnt < c_HW'(H_FRONT + H_SYNC)));
    assign w_vs0  = !((r_vcnt >= c_VW'(V_FRONT)) && (r_vcnt < c_VW'(V_FRONT + V_SYNC)));
    assign w_act0 = (r_hcnt >= c_HW'(c_H_BLANK)) && (r_vcnt >= c_VW'(c_V_BLANK));
    assign w_x0   = 12'(r_hcnt) - 12'(c_H_BLANK);
    assign w_y0   = 12'(r_vcnt) - 12'(c_V_BLANK);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix_en    <= 1'b0;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            frame_start <= 1'b0;
        end else begin
            r_pix_en    <= ~r_pix_en;
            // Enable toggles every clk, so this is high for exactly one clk.
            frame_start <= w_tick && w_h_last && w_v_last;
            if (w_tick) begin
                if (w_h_last) begin
                    r_hcnt <= '0;
                    r_vcnt <= w_v_last ? '0 : r_vcnt + c_VW'(1);
                end else begin
                    r_hcnt <= r_hcnt + c_HW'(1);
                end
            end
        end
    end

    for (genvar b = 0; b < N_BALLS; b++) begin : g_ball
        logic [11:0]        r_bx;
        logic [11:0]        r_by;
        logic               r_dirx;        // 1 = moving in + direction
        logic               r_diry;
        logic signed [12:0] w_nx;
        logic signed [12:0] w_ny;
        logic signed [11:0] r_dx;
        logic signed [11:0] r_dy;
        logic signed [23:0] w_dxe;
        logic signed [23:0] w_dye;
        logic [23:0]        w_d2;

        assign w_nx = r_dirx ? 13'(r_bx) + 13'(SPEED) : 13'(r_bx) - 13'(SPEED);
        assign w_ny = r_diry ? 13'(r_by) + 13'(SPEED) : 13'(r_by) - 13'(SPEED);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_bx   <= 12'(50 + 40 * b);
                r_by   <= 12'(50 + 30 * b);
                r_dirx <= (b % 2 == 0);
                r_diry <= (b % 2 != 0);
            end else if (frame_start && !pause) begin
                // Counters are at (0,0) here, well outside the active area.
                if (w_nx < c_RAD_S) begin
                    r_bx   <= 12'(RADIUS);
                    r_dirx <= 1'b1;
                end else if (w_nx > c_XMX_S) begin
                    r_bx   <= 12'(c_X_MAX);
                    r_dirx <= 1'b0;
                end else begin
                    r_bx   <= w_nx[11:0];
                end
                if (w_ny < c_RAD_S) begin
                    r_by   <= 12'(RADIUS);
                    r_diry <= 1'b1;
                end else if (w_ny > c_YMX_S) begin
                    r_by   <= 12'(c_Y_MAX);
                    r_diry <= 1'b0;
                end else begin
                    r_by   <= w_ny[11:0];
                end
            end
        end

        // Stage 1: signed offsets from the ball centre.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_dx <= '0;
                r_dy <= '0;
            end else if (w_tick) begin
                r_dx <= w_x0 - r_bx;
                r_dy <= w_y0 - r_by;
            end
        end

        // Stage 2 compare: squares of offsets bounded by the line length fit 24 bits.
        assign w_dxe    = 24'(r_dx);
        assign w_dye    = 24'(r_dy);
        assign w_d2     = 24'(w_dxe * w_dxe) + 24'(w_dye * w_dye);
        assign w_hit[b] = (w_d2 <= c_R2);
    end

    // Scan from highest index down so the lowest overlapping ball wins.
    always_comb begin
        w_rgb = 24'h000000;
        for (int b = N_BALLS - 1; b >= 0; b--) begin
            if (w_hit[b]) begin
                w_rgb = f_colour(b);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hs1       <= 1'b1;
            r_vs1       <= 1'b1;
            r_act1      <= 1'b0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            VGA_R       <= 8'h00;
            VGA_G       <= 8'h00;
            VGA_B       <= 8'h00;
        end else if (w_tick) begin
            r_hs1       <= w_hs0;
            r_vs1       <= w_vs0;
            r_act1      <= w_act0;
            VGA_HS      <= r_hs1;
            VGA_VS      <= r_vs1;
            VGA_BLANK_N <= r_act1;
            VGA_R       <= r_act1 ? w_rgb[23:16] : 8'h00;
            VGA_G       <= r_act1 ? w_rgb[15:8]  : 8'h00;
            VGA_B       <= r_act1 ? w_rgb[7:0]   : 8'h00;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_ball_engine
//  Purpose  : Self-checking bench. Two engines with reduced geometry:
//             A (4 balls, R=30) checks the pixel image against a reference
//             picture, B (3 balls, R=4, fast) exercises bouncing, clamping,
//             overlap priority and pause. A reference model recomputes every
//             output from pixel index, frame number and ball motion rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_ball_engine;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, nb, r, spd;
    } geom_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst;
    logic       pause_a;
    logic       pause_b;
    logic       a_hs, a_vs, a_blank, a_vclk, a_fs;
    logic [7:0] a_r, a_g, a_b;
    logic       b_hs, b_vs, b_blank, b_vclk, b_fs;
    logic [7:0] b_r, b_g, b_b;

    vga_ball_engine #(
        .H_ACT(160), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_ACT(144), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .N_BALLS(4), .RADIUS(30), .SPEED(1)
    ) u_dut_a (
        .clk(clk), .rst(rst), .pause(pause_a),
        .VGA_HS(a_hs), .VGA_VS(a_vs), .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b),
        .VGA_BLANK_N(a_blank), .VGA_CLOCK(a_vclk), .frame_start(a_fs)
    );

    vga_ball_engine #(
        .H_ACT(60), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_ACT(40), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .N_BALLS(3), .RADIUS(4), .SPEED(9)
    ) u_dut_b (
        .clk(clk), .rst(rst), .pause(pause_b),
        .VGA_HS(b_hs), .VGA_VS(b_vs), .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b),
        .VGA_BLANK_N(b_blank), .VGA_CLOCK(b_vclk), .frame_start(b_fs)
    );

    geom_t g[2];
    int    bx[2][8], by[2][8], sx[2][8], sy[2][8];
    int    pbx[2][8], pby[2][8];
    int    nup[2];
    int    k;
    int    n_vec;
    int    n_err;
    logic  pause_rnd;

    function automatic int htot(input int d);
        return g[d].hf + g[d].hs + g[d].hb + g[d].ha;
    endfunction

    function automatic int vtot(input int d);
        return g[d].vf + g[d].vs + g[d].vb + g[d].va;
    endfunction

    function automatic int fpix(input int d);
        return htot(d) * vtot(d);
    endfunction

    function automatic logic [23:0] colour(input int idx);
        case (idx % 4)
            0:       return 24'h0000ff;
            1:       return 24'h00ff00;
            2:       return 24'hff0000;
            default: return 24'hffffff;
        endcase
    endfunction

    task automatic chk(input int d, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL dut%0d %s: got %h, expected %h (k=%0d t=%0t)", d, name, act, exp, k, $time);
        end
    endtask

    task automatic model_reset(input int d);
        for (int b = 0; b < 8; b++) begin
            bx[d][b]  = 50 + 40 * b;
            by[d][b]  = 50 + 30 * b;
            sx[d][b]  = (b % 2 == 0) ? 1 : -1;
            sy[d][b]  = (b % 2 == 0) ? -1 : 1;
            pbx[d][b] = bx[d][b];
            pby[d][b] = by[d][b];
        end
        nup[d] = 0;
    endtask

    task automatic move(input int pos, input int dir, input int lim, input int r, input int spd,
                        output int npos, output int ndir);
        int nxt;
        nxt  = pos + dir * spd;
        npos = nxt;
        ndir = dir;
        if (nxt < r) begin
            npos = r;
            ndir = 1;
        end else if (nxt > lim - 1 - r) begin
            npos = lim - 1 - r;
            ndir = -1;
        end
    endtask

    task automatic model_frame(input int d, input logic paused);
        int p, s;
        for (int b = 0; b < 8; b++) begin
            pbx[d][b] = bx[d][b];
            pby[d][b] = by[d][b];
        end
        nup[d]++;
        if (!paused) begin
            for (int b = 0; b < g[d].nb; b++) begin
                move(bx[d][b], sx[d][b], g[d].ha, g[d].r, g[d].spd, p, s);
                bx[d][b] = p;
                sx[d][b] = s;
                move(by[d][b], sy[d][b], g[d].va, g[d].r, g[d].spd, p, s);
                by[d][b] = p;
                sy[d][b] = s;
            end
        end
    endtask

    task automatic get_out(input int d, output logic hs, output logic vs, output logic blank,
                           output logic vclk, output logic fs, output logic [23:0] rgb);
        if (d == 0) begin
            hs = a_hs; vs = a_vs; blank = a_blank; vclk = a_vclk; fs = a_fs; rgb = {a_r, a_g, a_b};
        end else begin
            hs = b_hs; vs = b_vs; blank = b_blank; vclk = b_vclk; fs = b_fs; rgb = {b_r, b_g, b_b};
        end
    endtask

    task automatic check_reset_outputs(input int d);
        logic hs, vs, blank, vclk, fs;
        logic [23:0] rgb;
        get_out(d, hs, vs, blank, vclk, fs, rgb);
        chk(d, "rst_hs", 32'(hs), 32'd1);
        chk(d, "rst_vs", 32'(vs), 32'd1);
        chk(d, "rst_blank_n", 32'(blank), 32'd0);
        chk(d, "rst_rgb", 32'(rgb), 32'd0);
        chk(d, "rst_frame_start", 32'(fs), 32'd0);
    endtask

    // Outputs seen after posedge k show pixel floor(k/2)-2 of the raster.
    task automatic check_dut(input int d);
        logic hs, vs, blank, vclk, fs;
        logic [23:0] rgb;
        logic ehs, evs, eact;
        logic [23:0] ergb;
        int j, p, fp, q, h, v, x, y, cx, cy, hbl, vbl;
        bit found;
        get_out(d, hs, vs, blank, vclk, fs, rgb);
        j    = k / 2;
        ehs  = 1'b1;
        evs  = 1'b1;
        eact = 1'b0;
        ergb = 24'h0;
        if (j >= 2) begin
            p   = j - 2;
            fp  = p / fpix(d);
            q   = p % fpix(d);
            h   = q % htot(d);
            v   = q / htot(d);
            hbl = g[d].hf + g[d].hs + g[d].hb;
            vbl = g[d].vf + g[d].vs + g[d].vb;
            ehs  = !(h >= g[d].hf && h < g[d].hf + g[d].hs);
            evs  = !(v >= g[d].vf && v < g[d].vf + g[d].vs);
            eact = (h >= hbl) && (v >= vbl);
            if (eact) begin
                x = h - hbl;
                y = v - vbl;
                found = 0;
                for (int b = 0; b < g[d].nb; b++) begin
                    cx = (fp == nup[d]) ? bx[d][b] : pbx[d][b];
                    cy = (fp == nup[d]) ? by[d][b] : pby[d][b];
                    if (!found && (x - cx) * (x - cx) + (y - cy) * (y - cy) <= g[d].r * g[d].r) begin
                        found = 1;
                        ergb  = colour(b);
                    end
                end
                if (d == 0 && fp == 0 && k % 2 == 0) begin
                    if (x == 50 && y == 50) chk(d, "pin_px_50_50", 32'(rgb), 32'h0000ff);
                    if (x == 90 && y == 80) chk(d, "pin_px_90_80", 32'(rgb), 32'h00ff00);
                    if (x == 81 && y == 50) chk(d, "pin_px_81_50", 32'(rgb), 32'h000000);
                end
            end
        end
        chk(d, "hs", 32'(hs), 32'(ehs));
        chk(d, "vs", 32'(vs), 32'(evs));
        chk(d, "blank_n", 32'(blank), 32'(eact));
        chk(d, "rgb", 32'(rgb), 32'(ergb));
        chk(d, "vga_clock", 32'(vclk), 32'(k % 2 == 0));
        chk(d, "frame_start", 32'(fs), 32'(k > 0 && k % (2 * fpix(d)) == 0));
    endtask

    task automatic step();
        logic forced;
        k++;
        check_dut(0);
        check_dut(1);
        // Random mid-frame pause edges on B, plus a forced 3-frame hold.
        if (k > 2 * fpix(1) + 10 && $urandom_range(0, 2999) == 0) pause_rnd = ~pause_rnd;
        forced  = (k >= 2 * fpix(1) * 3 + 100) && (k < 2 * fpix(1) * 6 + 100);
        pause_b = forced || pause_rnd;
        for (int d = 0; d < 2; d++) begin
            if (k % (2 * fpix(d)) == 0) model_frame(d, (d == 0) ? pause_a : pause_b);
        end
        // First update of B drives every ball into the lower-right clamp.
        if (k == 2 * fpix(1) + 1) begin
            chk(1, "model_pin_b0_x", 32'(bx[1][0]), 32'd55);
            chk(1, "model_pin_b0_y", 32'(by[1][0]), 32'd35);
            chk(1, "model_pin_b0_dx", 32'(sx[1][0]), 32'hffffffff);
            chk(1, "model_pin_b2_y", 32'(by[1][2]), 32'd35);
        end
    endtask

    initial begin
        g[0] = '{ha:160, hf:2, hs:4, hb:2, va:144, vf:1, vs:2, vb:1, nb:4, r:30, spd:1};
        g[1] = '{ha:60,  hf:1, hs:2, hb:1, va:40,  vf:1, vs:1, vb:1, nb:3, r:4,  spd:9};
        n_vec     = 0;
        n_err     = 0;
        k         = 0;
        rst       = 1'b0;
        pause_a   = 1'b0;
        pause_b   = 1'b0;
        pause_rnd = 1'b0;
        model_reset(0);
        model_reset(1);

        repeat (3) @(negedge clk);
        check_reset_outputs(0);
        check_reset_outputs(1);
        rst = 1'b1;

        repeat (52000) begin
            @(negedge clk);
            step();
        end

        // Engine A is now mid-way through an active line of its second frame.
        @(posedge clk);
        #5 rst = 1'b0;
        #1;
        check_reset_outputs(0);
        check_reset_outputs(1);
        model_reset(0);
        model_reset(1);
        k         = 0;
        pause_rnd = 1'b0;
        pause_b   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        repeat (12000) begin
            @(negedge clk);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
